serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract sequencer for the ALU. It feeds one full-adder cell with one operand bit per clock, LSB first, carrying the carry from cycle to cycle, and shifts the sum into a result register. It runs a start/busy/done handshake and produces the Y86 condition-code inputs. It is the low-area alternative to the parallel ripple adder/subtractor and sits between the execute-stage control and the condition-code register.

---
 rtl/serial_addsub_ctrl_if.sv | 27 ++
 rtl/serial_addsub_ctrl.sv | 145 ++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_ctrl_if.sv
// serial_addsub_ctrl_if: request/response bundle between execute control and the
// bit-serial add/subtract sequencer.
interface serial_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zf, sf, of
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zf, sf, of
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: one-bit-per-cycle add/subtract, LSB first, with start/busy/done handshake.
// Define SERIAL_ADDSUB_FLAGS_EN to build the zf/sf/of condition-code logic.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_addsub_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               sum_c;

  // Sequencer: load on accept, one full-adder step per RUN cycle, single DONE cycle
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    sum_c    = op_a_q[0] ^ op_b_q[0] ^ carry_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.op ? ~bus.b : bus.b;
          carry_d = bus.op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d  = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
        op_a_d   = op_a_q >> 1;
        op_b_d   = op_b_q >> 1;
        result_d = {sum_c, result_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cout_d  = carry_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic zf_q, zf_d;
  logic sf_q, sf_d;
  logic of_q, of_d;
  logic c_msb_c;

  // Flags latch on the edge that processes the MSB (done_d marks that edge)
  always_comb begin
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    c_msb_c = carry_q;
    if (done_d) begin
      zf_d = (result_d == '0);
      sf_d = result_d[WIDTH-1];
      of_d = c_msb_c ^ carry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign bus.zf = zf_q;
  assign bus.sf = sf_q;
  assign bus.of = of_q;
`else
  assign bus.zf = 1'b0;
  assign bus.sf = 1'b0;
  assign bus.of = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed bench for a 64-bit and an 8-bit instance, checked against
// an arithmetic reference model every cycle plus hand-computed literals.
module tb_serial_addsub_ctrl;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int wd [2] = '{64, 8};

  logic        start_v [2] = '{1'b0, 1'b0};
  logic        op_v    [2] = '{1'b0, 1'b0};
  logic [63:0] a_v     [2] = '{64'd0, 64'd0};
  logic [63:0] b_v     [2] = '{64'd0, 64'd0};
  logic        busy_o [2], done_o [2], cout_o [2], zf_o [2], sf_o [2], of_o [2];
  logic [63:0] res_o  [2];

  serial_addsub_ctrl_if #(.WIDTH(64)) if64 ();
  serial_addsub_ctrl_if #(.WIDTH(8))  if8  ();

  serial_addsub_ctrl #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));
  serial_addsub_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  assign if64.start = start_v[0];
  assign if64.op    = op_v[0];
  assign if64.a     = a_v[0];
  assign if64.b     = b_v[0];
  assign if8.start  = start_v[1];
  assign if8.op     = op_v[1];
  assign if8.a      = a_v[1][7:0];
  assign if8.b      = b_v[1][7:0];

  assign busy_o[0] = if64.busy;  assign busy_o[1] = if8.busy;
  assign done_o[0] = if64.done;  assign done_o[1] = if8.done;
  assign res_o[0]  = if64.result; assign res_o[1] = 64'(if8.result);
  assign cout_o[0] = if64.cout;  assign cout_o[1] = if8.cout;
  assign zf_o[0]   = if64.zf;    assign zf_o[1]   = if8.zf;
  assign sf_o[0]   = if64.sf;    assign sf_o[1]   = if8.sf;
  assign of_o[0]   = if64.of;    assign of_o[1]   = if8.of;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: {of, sf, zf, cout, result} from modular arithmetic and sign rules
  function automatic logic [67:0] calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                       input logic op);
    logic [63:0] mask, am, bv, r;
    logic [64:0] full;
    logic        c, ovf, z, s;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bv   = (op ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bv} + 65'(op);
    r    = full[63:0] & mask;
    c    = full[w];
    ovf  = (am[w-1] == bv[w-1]) && (r[w-1] != am[w-1]);
    z    = (r == 64'd0);
    s    = r[w-1];
    return {ovf & FL, s & FL, z & FL, c, r};
  endfunction

  // Model phase: 0 idle, k = k-th cycle after the accepting edge; done at WIDTH+1
  int          m_ph  [2] = '{0, 0};
  logic [67:0] p_val [2] = '{68'd0, 68'd0};
  logic [67:0] m_val [2] = '{68'd0, 68'd0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_ph[d]  <= 0;
        m_val[d] <= '0;
      end else if (m_ph[d] == 0) begin
        if (start_v[d]) begin
          m_ph[d]  <= 1;
          p_val[d] <= calc(wd[d], a_v[d], b_v[d], op_v[d]);
        end
      end else if (m_ph[d] == wd[d]) begin
        m_ph[d]  <= m_ph[d] + 1;
        m_val[d] <= p_val[d];
      end else if (m_ph[d] == wd[d] + 1) begin
        m_ph[d] <= 0;
      end else begin
        m_ph[d] <= m_ph[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy_w%0d", wd[d]), 64'(busy_o[d]), 64'(m_ph[d] != 0));
      check($sformatf("done_w%0d", wd[d]), 64'(done_o[d]), 64'(m_ph[d] == wd[d] + 1));
      if (m_ph[d] == 0 || m_ph[d] == wd[d] + 1) begin
        check($sformatf("result_w%0d", wd[d]), res_o[d], m_val[d][63:0]);
        check($sformatf("cout_w%0d", wd[d]), 64'(cout_o[d]), 64'(m_val[d][64]));
        check($sformatf("zf_w%0d", wd[d]), 64'(zf_o[d]), 64'(m_val[d][65]));
        check($sformatf("sf_w%0d", wd[d]), 64'(sf_o[d]), 64'(m_val[d][66]));
        check($sformatf("of_w%0d", wd[d]), 64'(of_o[d]), 64'(m_val[d][67]));
      end
    end
  end

  // Wait for done with a cycle budget; n counts edges including the accepting one
  task automatic wait_done(input int d, input int glitch, output int n);
    n = 1;
    while (!done_o[d] && n < 400) begin
      start_v[d] = (glitch != 0 && n == glitch);
      @(posedge clk); #1;
      n++;
    end
    start_v[d] = 1'b0;
    check($sformatf("done_seen_w%0d", wd[d]), 64'(done_o[d]), 64'd1);
  endtask

  task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b, input logic op,
                        input logic [63:0] er, input logic ec, input logic ez, input logic es,
                        input logic eo, input int glitch);
    int n;
    @(posedge clk); #1;
    a_v[d] = a; b_v[d] = b; op_v[d] = op; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0; a_v[d] = ~a; b_v[d] = ~b; op_v[d] = ~op;
    check("lit_busy_after_accept", 64'(busy_o[d]), 64'd1);
    wait_done(d, glitch, n);
    check("lit_latency", 64'(n), 64'(wd[d] + 1));
    check("lit_result", res_o[d], er);
    check("lit_cout", 64'(cout_o[d]), 64'(ec));
    check("lit_zf", 64'(zf_o[d]), 64'(ez & FL));
    check("lit_sf", 64'(sf_o[d]), 64'(es & FL));
    check("lit_of", 64'(of_o[d]), 64'(eo & FL));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset asserted with start held high
    #1;
    rst_n = 1'b0;
    start_v[0] = 1'b1; a_v[0] = 64'hDEAD; b_v[0] = 64'hBEEF;
    start_v[1] = 1'b1; a_v[1] = 64'h12;   b_v[1] = 64'h34;
    repeat (4) @(posedge clk);
    #1;
    check("lit_rst_busy", 64'(busy_o[0]), 64'd0);
    check("lit_rst_done", 64'(done_o[0]), 64'd0);
    check("lit_rst_result", res_o[0], 64'd0);
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lit_idle_busy", 64'(busy_o[0]), 64'd0);

    run_op(0, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op(0, 64'h1234, 64'h1234, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_op(1, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    run_op(1, 64'h80, 64'h01, 1'b1, 64'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    // start pulsed mid-RUN with scrambled operands must be ignored
    run_op(0, 64'd100, 64'd200, 1'b0, 64'd300, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    run_op(1, 64'h05, 64'h09, 1'b1, 64'hFC, 1'b0, 1'b0, 1'b1, 1'b0, 4);

    // start held continuously: next accept one idle cycle after DONE
    @(posedge clk); #1;
    a_v[1] = 64'd3; b_v[1] = 64'd4; op_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    a_v[1] = 64'd10; b_v[1] = 64'd1;
    n = 1;
    while (!done_o[1] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("lit_held_latency", 64'(n), 64'd9);
    check("lit_held_result1", res_o[1], 64'd7);
    @(posedge clk); #1;
    check("lit_held_gap_busy", 64'(busy_o[1]), 64'd0);
    @(posedge clk); #1;
    check("lit_held_reaccept_busy", 64'(busy_o[1]), 64'd1);
    start_v[1] = 1'b0;
    wait_done(1, 0, n);
    check("lit_held_result2", res_o[1], 64'd11);

    // Abort a 64-bit add at bit 30
    @(posedge clk); #1;
    a_v[0] = 64'h1111; b_v[0] = 64'h2222; op_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("lit_abort_busy_before", 64'(busy_o[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("lit_abort_busy", 64'(busy_o[0]), 64'd0);
    check("lit_abort_result", res_o[0], 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lit_abort_no_done", 64'(done_o[0]), 64'd0);
    check("lit_abort_result_after", res_o[0], 64'd0);

    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
           1'b1, 1'b0, 1'b0, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
